fpnew_result_collector: RTL and testbench
=========================================

Name: fpnew_result_collector

Overview:
- Consumer end of the FP operation-unit output handshake (result/status/extension_bit/tag, valid/ready).
- Buffers completed results in a small FIFO and widens each result to FLEN for register-file writeback, using the extension bit: NaN-boxing for floats, sign-extension/zero for integer results.
- Accumulates sticky exception flags (fflags) on commit.
- Sits between the operation-unit output and the core writeback port.

Parameters:
- WIDTH, 32, width of incoming result (operation-unit format width).
- FLEN, 64, writeback width; must be >= WIDTH.
- DEPTH, 2, FIFO entries; must be >= 1, any integer (not restricted to a power of two).
- TAG_WIDTH, 8, width of the operation tag carried alongside each result.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_result_i  in  WIDTH  result from the operation unit
- in_status_i  in  5  status {NV,DZ,OF,UF,NX}
- in_extension_bit_i  in  1  fill value for the upper FLEN-WIDTH bits
- in_tag_i  in  TAG_WIDTH  operation tag
- in_valid_i  in  1  unit output valid
- in_ready_o  out  1  collector can accept
- flush_i  in  1  discard all buffered entries
- wb_data_o  out  FLEN  widened result
- wb_status_o  out  5  status of the head entry
- wb_tag_o  out  TAG_WIDTH  tag of the head entry
- wb_valid_o  out  1  head entry valid
- wb_ready_i  in  1  writeback accepts
- fflags_clr_i  in  1  clear the sticky flags
- fflags_o  out  5  sticky accumulated flags
- busy_o  out  1  at least one entry held

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (rst_ni).
- Reset values:
  - FIFO empty; read/write pointers = 0; count = 0.
  - fflags_o = 0; wb_valid_o = 0; busy_o = 0; in_ready_o = 1 (when DEPTH >= 1).
  - wb_data_o, wb_status_o and wb_tag_o = 0 while empty.
- Push: on in_valid_i && in_ready_o, store {result, status, extension_bit, tag} at the write pointer.
  - Write pointer increments and wraps DEPTH-1 -> 0.
- in_ready_o = (count != DEPTH).
  - When full, a push is not accepted even if a pop occurs in the same cycle.
  - This keeps in_ready_o free of any combinational path from wb_ready_i.
- Pop: on wb_valid_o && wb_ready_i, advance the read pointer (with wrap).
- wb_valid_o = (count != 0). Data is registered, so push-to-wb_valid_o latency is 1 cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Widening:
  - wb_data_o[WIDTH-1:0] = head result.
  - wb_data_o[FLEN-1:WIDTH] = replicated head extension bit.
  - FLEN == WIDTH: no fill.
- Flag accumulation:
  - On each pop: fflags_q <= fflags_q | head status.
  - fflags_clr_i without a pop: fflags_q <= 0.
  - fflags_clr_i with a pop in the same cycle: fflags_q <= head status (clear first, then OR).
  - Flags are never updated on push.
- Flush:
  - flush_i sets count = 0 and read pointer = write pointer in the next cycle.
  - A push in the same cycle is discarded.
  - A pop handshake in the same cycle still updates fflags.
  - fflags is otherwise unaffected by flush.
- Reset asserted mid-operation: all entries are lost immediately (asynchronous); fflags cleared.
- busy_o = (count != 0).
- Stability: wb_* outputs must not change while wb_valid_o && !wb_ready_i, except on flush or reset.
- in_valid_i may be deasserted freely; no obligation is placed on the producer beyond the handshake.

Optional Feature:
- Macro: FPNEW_COLLECTOR_BYPASS_EN.
- Defined:
  - When count == 0 and in_valid_i is high, wb_* is driven combinationally from the in_* inputs, and wb_valid_o = in_valid_i.
  - If wb_ready_i is also high, the result is consumed in the same cycle without being written to the FIFO (0-cycle latency). fflags updates as for a pop.
  - in_ready_o is unchanged.
  - While flush_i is high, the bypass is suppressed.
- Undefined: always 1-cycle latency through storage; no combinational path from in_* to wb_*.

Test Plan:
- Widening: WIDTH=32, FLEN=64. Push result 0x3F800000 with ext=1, then pop -> wb_data_o = 0xFFFFFFFF_3F800000. Push 0x80000000 with ext=0 -> wb_data_o = 0x00000000_80000000.
- Full/backpressure: DEPTH=2, wb_ready_i=0. Push tags 0x11 and 0x22 -> in_ready_o=0 after the 2nd push; a 3rd in_valid_i is not accepted. Then pop twice -> tags 0x11, 0x22 in order; busy_o=0 afterwards.
- Flags: pop statuses 5'b10000 then 5'b00001 -> fflags_o = 5'b10001. Then assert fflags_clr_i together with a pop of status 5'b00100 -> fflags_o = 5'b00100.
- Flush with a concurrent push while holding 2 entries -> next cycle wb_valid_o=0, busy_o=0, in_ready_o=1; fflags_o unchanged.
- Wrap-around: DEPTH=3, 10 back-to-back push/pop pairs with random wb_ready_i -> tag order preserved across pointer wrap; no loss or duplication.
- Bypass (macro defined): empty FIFO, in_valid_i=1, wb_ready_i=1, tag 0x5A -> wb_valid_o=1 with wb_tag_o=0x5A in the same cycle; count stays 0. Without the macro, wb_valid_o rises one cycle later.

Source files
------------

// File: rtl/fpnew_result_collector.sv
// Result collector for the FP operation-unit output: buffers results in a small FIFO,
// widens them to FLEN for writeback and accumulates sticky fflags.
// Optional same-cycle bypass when empty: define FPNEW_COLLECTOR_BYPASS_EN.
module fpnew_result_collector #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FLEN      = 64,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned TAG_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [WIDTH-1:0]     in_result_i,
    input  logic [4:0]           in_status_i,
    input  logic                 in_extension_bit_i,
    input  logic [TAG_WIDTH-1:0] in_tag_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output logic [FLEN-1:0]      wb_data_o,
    output logic [4:0]           wb_status_o,
    output logic [TAG_WIDTH-1:0] wb_tag_o,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    input  logic                 fflags_clr_i,
    output logic [4:0]           fflags_o,
    output logic                 busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (FLEN < WIDTH) begin : g_bad_flen
        $error("fpnew_result_collector: FLEN must be >= WIDTH");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("fpnew_result_collector: DEPTH must be >= 1");
    end

    logic [WIDTH-1:0]     r_result [DEPTH];
    logic [4:0]           r_status [DEPTH];
    logic                 r_ext    [DEPTH];
    logic [TAG_WIDTH-1:0] r_tag    [DEPTH];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [4:0]       r_fflags;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_pop_fifo;
    logic [WIDTH-1:0]     w_result;
    logic                 w_ext;
    logic [PTR_W-1:0]     w_wptr_inc;
    logic [PTR_W-1:0]     w_rptr_inc;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // Ready depends only on occupancy, never on wb_ready_i.
    assign in_ready_o = !w_full;
    assign busy_o     = !w_empty;
    assign fflags_o   = r_fflags;

`ifdef FPNEW_COLLECTOR_BYPASS_EN
    assign w_bypass = w_empty && in_valid_i && !flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_result    = '0;
        w_ext       = 1'b0;
        wb_status_o = '0;
        wb_tag_o    = '0;
        if (w_bypass) begin
            w_result    = in_result_i;
            w_ext       = in_extension_bit_i;
            wb_status_o = in_status_i;
            wb_tag_o    = in_tag_i;
        end else if (!w_empty) begin
            w_result    = r_result[r_rptr];
            w_ext       = r_ext[r_rptr];
            wb_status_o = r_status[r_rptr];
            wb_tag_o    = r_tag[r_rptr];
        end
    end

    assign wb_valid_o = w_bypass || !w_empty;

    if (FLEN > WIDTH) begin : g_widen
        assign wb_data_o = {{(FLEN - WIDTH){w_ext}}, w_result};
    end else begin : g_no_widen
        assign wb_data_o = w_result;
    end

    assign w_pop      = wb_valid_o && wb_ready_i;
    assign w_pop_fifo = w_pop && !w_bypass;
    // A bypassed result that is consumed immediately never touches storage.
    assign w_push     = in_valid_i && in_ready_o && !flush_i && !(w_bypass && wb_ready_i);

    assign w_wptr_inc = (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
    assign w_rptr_inc = (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_result[i] <= '0;
                r_status[i] <= '0;
                r_ext[i]    <= 1'b0;
                r_tag[i]    <= '0;
            end
        end else if (w_push) begin
            r_result[r_wptr] <= in_result_i;
            r_status[r_wptr] <= in_status_i;
            r_ext[r_wptr]    <= in_extension_bit_i;
            r_tag[r_wptr]    <= in_tag_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_rptr  <= r_wptr;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_pop_fifo) begin
                r_rptr <= w_rptr_inc;
            end
            unique case ({w_push, w_pop_fifo})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear takes effect before the OR of a same-cycle pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fflags <= '0;
        end else if (fflags_clr_i) begin
            r_fflags <= w_pop ? wb_status_o : 5'b0;
        end else if (w_pop) begin
            r_fflags <= r_fflags | wb_status_o;
        end
    end

endmodule

// File: tb/tb_fpnew_result_collector.sv
// Directed self-checking bench for fpnew_result_collector (DEPTH=2 and DEPTH=3 instances).
module tb_fpnew_result_collector;

    logic clk;
    logic rst_n;

    logic [31:0] in_result;
    logic [4:0]  in_status;
    logic        in_ext;
    logic [7:0]  in_tag;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [63:0] wb_data;
    logic [4:0]  wb_status;
    logic [7:0]  wb_tag;
    logic        wb_valid;
    logic        wb_ready;
    logic        fflags_clr;
    logic [4:0]  fflags;
    logic        busy;

    logic [7:0]  in_tag3;
    logic        in_valid3;
    logic        in_ready3;
    logic [63:0] wb_data3;
    logic [4:0]  wb_status3;
    logic [7:0]  wb_tag3;
    logic        wb_valid3;
    logic        wb_ready3;
    logic [4:0]  fflags3;
    logic        busy3;

    int n_cmp;
    int n_err;
    int sent;
    int recv;
    bit push_fire;
    bit pop_fire;

    fpnew_result_collector #(
        .WIDTH(32), .FLEN(64), .DEPTH(2), .TAG_WIDTH(8)
    ) u_dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .in_result_i        (in_result),
        .in_status_i        (in_status),
        .in_extension_bit_i (in_ext),
        .in_tag_i           (in_tag),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .flush_i            (flush),
        .wb_data_o          (wb_data),
        .wb_status_o        (wb_status),
        .wb_tag_o           (wb_tag),
        .wb_valid_o         (wb_valid),
        .wb_ready_i         (wb_ready),
        .fflags_clr_i       (fflags_clr),
        .fflags_o           (fflags),
        .busy_o             (busy)
    );

    fpnew_result_collector #(
        .WIDTH(32), .FLEN(64), .DEPTH(3), .TAG_WIDTH(8)
    ) u_dut3 (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .in_result_i        (32'h0),
        .in_status_i        (5'b0),
        .in_extension_bit_i (1'b0),
        .in_tag_i           (in_tag3),
        .in_valid_i         (in_valid3),
        .in_ready_o         (in_ready3),
        .flush_i            (1'b0),
        .wb_data_o          (wb_data3),
        .wb_status_o        (wb_status3),
        .wb_tag_o           (wb_tag3),
        .wb_valid_o         (wb_valid3),
        .wb_ready_i         (wb_ready3),
        .fflags_clr_i       (1'b0),
        .fflags_o           (fflags3),
        .busy_o             (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] res, input logic [4:0] st, input logic ext,
                        input logic [7:0] tag);
        in_result = res;
        in_status = st;
        in_ext    = ext;
        in_tag    = tag;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic pop();
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_result = '0; in_status = '0; in_ext = 1'b0; in_tag = '0; in_valid = 1'b0;
        flush = 1'b0; wb_ready = 1'b0; fflags_clr = 1'b0;
        in_tag3 = '0; in_valid3 = 1'b0; wb_ready3 = 1'b0;
        #12;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fflags", fflags, 0);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_wb_tag", wb_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Widening
        push(32'h3F80_0000, 5'b0, 1'b1, 8'h01);
        check_eq("widen1_valid", wb_valid, 1);
        check_eq("widen1_data", wb_data, 64'hFFFF_FFFF_3F80_0000);
        pop();
        push(32'h8000_0000, 5'b0, 1'b0, 8'h02);
        check_eq("widen0_data", wb_data, 64'h0000_0000_8000_0000);
        pop();
        check_eq("widen_busy", busy, 0);

        // Full / backpressure
        push(32'h0, 5'b0, 1'b0, 8'h11);
        check_eq("full_ready1", in_ready, 1);
        push(32'h0, 5'b0, 1'b0, 8'h22);
        check_eq("full_ready2", in_ready, 0);
        in_tag = 8'h33; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("full_ready3", in_ready, 0);
        check_eq("full_head1", wb_tag, 8'h11);
        pop();
        check_eq("full_head2", wb_tag, 8'h22);
        check_eq("full_ready4", in_ready, 1);
        pop();
        check_eq("full_busy", busy, 0);
        check_eq("full_valid", wb_valid, 0);
        check_eq("full_fflags", fflags, 0);

        // Sticky flags
        push(32'h0, 5'b10000, 1'b0, 8'h41);
        push(32'h0, 5'b00001, 1'b0, 8'h42);
        check_eq("flag_nopush", fflags, 0);
        pop();
        check_eq("flag_first", fflags, 5'b10000);
        pop();
        check_eq("flag_or", fflags, 5'b10001);
        push(32'h0, 5'b00100, 1'b0, 8'h43);
        fflags_clr = 1'b1;
        pop();
        fflags_clr = 1'b0;
        check_eq("flag_clr_pop", fflags, 5'b00100);
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        check_eq("flag_clr", fflags, 0);
        push(32'h0, 5'b01000, 1'b0, 8'h44);
        pop();
        check_eq("flag_pre_flush", fflags, 5'b01000);

        // Flush with concurrent push while holding two entries
        push(32'h0, 5'b00010, 1'b0, 8'h51);
        push(32'h0, 5'b00010, 1'b0, 8'h52);
        flush = 1'b1; in_tag = 8'h77; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_valid", wb_valid, 0);
        check_eq("flush_busy", busy, 0);
        check_eq("flush_ready", in_ready, 1);
        check_eq("flush_fflags", fflags, 5'b01000);
        tick();
        check_eq("flush_discard", wb_valid, 0);
        push(32'h0, 5'b0, 1'b0, 8'h88);
        check_eq("flush_after_tag", wb_tag, 8'h88);
        pop();
        check_eq("flush_after_busy", busy, 0);

        // Bypass / latency
        in_result = 32'h1234_5678; in_status = 5'b0; in_ext = 1'b0; in_tag = 8'h5A;
        in_valid = 1'b1; wb_ready = 1'b1;
        #1;
`ifdef FPNEW_COLLECTOR_BYPASS_EN
        check_eq("byp_valid", wb_valid, 1);
        check_eq("byp_tag", wb_tag, 8'h5A);
`else
        check_eq("byp_valid", wb_valid, 0);
`endif
        tick();
        in_valid = 1'b0;
`ifdef FPNEW_COLLECTOR_BYPASS_EN
        check_eq("byp_busy", busy, 0);
        check_eq("byp_after", wb_valid, 0);
        wb_ready = 1'b0;
`else
        check_eq("lat_valid", wb_valid, 1);
        check_eq("lat_tag", wb_tag, 8'h5A);
        wb_ready = 1'b0;
        pop();
        check_eq("lat_busy", busy, 0);
`endif

        // Wrap-around on DEPTH=3
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
            in_valid3 = (sent < 10);
            in_tag3   = 8'hA0 + 8'(sent);
            wb_ready3 = 1'($urandom_range(0, 1));
            #3;
            push_fire = in_valid3 && in_ready3;
            pop_fire  = wb_valid3 && wb_ready3;
            if (pop_fire) begin
                check_eq("wrap_tag", wb_tag3, 8'hA0 + 8'(recv));
                recv++;
            end
            if (push_fire) sent++;
            tick();
        end
        in_valid3 = 1'b0;
        wb_ready3 = 1'b0;
        check_eq("wrap_count", 64'(recv), 10);
        tick();
        check_eq("wrap_busy", busy3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
